// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared types, key code and screen bounds for the tank game slice
package tank_pkg;

    typedef logic [9:0] coord_t;

    localparam logic [7:0] KEY_FIRE = 8'h2C;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic {READY, COOLDOWN} fire_state_t;
    typedef enum logic {FREE, FLIGHT}    slot_state_t;

    function automatic logic is_fire_key(input logic [7:0] key);
        return key == KEY_FIRE;
    endfunction

endpackage

// File: rtl/shell_ctrl_if.sv
// rtl/shell_ctrl_if.sv - keyboard/tank inputs and shell outputs of the shell controller
interface shell_ctrl_if import tank_pkg::*; #(
    parameter int NUM_SHELLS = 4
) ();

    logic [7:0]               keycode;
    coord_t                   TankX;
    coord_t                   TankY;
    logic [NUM_SHELLS*10-1:0] ShellX;
    logic [NUM_SHELLS*10-1:0] ShellY;
    logic [NUM_SHELLS-1:0]    ShellActive;
    logic                     FirePulse;

    modport master (
        output keycode, TankX, TankY,
        input  ShellX, ShellY, ShellActive, FirePulse
    );

    modport slave (
        input  keycode, TankX, TankY,
        output ShellX, ShellY, ShellActive, FirePulse
    );

endinterface

// File: rtl/shell_ctrl_slot.sv
// rtl/shell_ctrl_slot.sv - one projectile slot: launch capture, upward step, top retire
module shell_slot import tank_pkg::*; #(
    parameter int SHELL_STEP = 4,
    parameter int Y_MIN      = 0
) (
    input  logic   frame_clk,
    input  logic   Reset,
    input  logic   launch_i,
    input  coord_t spawn_x_i,
    input  coord_t spawn_y_i,
    output coord_t x_o,
    output coord_t y_o,
    output logic   active_o
);

    localparam coord_t STEP         = coord_t'(SHELL_STEP);
    // Compared before subtracting so y never wraps below Y_MIN.
    localparam coord_t RETIRE_BELOW = coord_t'(Y_MIN + SHELL_STEP);

    slot_state_t state_q;
    coord_t      x_q;
    coord_t      y_q;

    // Slot FSM: capture spawn position on launch, then climb until the top boundary.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= FREE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            case (state_q)
                FREE: begin
                    if (launch_i) begin
                        state_q <= FLIGHT;
                        x_q     <= spawn_x_i;
                        y_q     <= spawn_y_i;
                    end
                end
                FLIGHT: begin
                    if (y_q < RETIRE_BELOW) begin
                        state_q <= FREE;
                    end else begin
                        y_q <= y_q - STEP;
                    end
                end
                default: state_q <= FREE;
            endcase
        end
    end

    assign x_o      = x_q;
    assign y_o      = y_q;
    assign active_o = (state_q == FLIGHT);

endmodule

// File: rtl/shell_ctrl.sv
// rtl/shell_ctrl.sv - fire FSM and slot allocator for tank shells; SHELL_AUTOFIRE_EN enables hold-to-repeat
module shell_ctrl import tank_pkg::*; #(
    parameter int NUM_SHELLS   = 4,
    parameter int SHELL_STEP   = 4,
    parameter int SPAWN_OFFSET = 8,
    parameter int COOLDOWN     = 15,
    parameter int Y_MIN        = 0
) (
    input  logic         frame_clk,
    input  logic         Reset,
    shell_ctrl_if.slave  bus
);

    localparam int               CNT_W     = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN);
    localparam logic [CNT_W-1:0] CNT_LOAD  = (COOLDOWN == 0) ? '0 : CNT_W'(COOLDOWN - 1);
    localparam coord_t           SPAWN_MIN = coord_t'(Y_MIN + SPAWN_OFFSET);
    localparam coord_t           SPAWN_OFF = coord_t'(SPAWN_OFFSET);

    fire_state_t       fire_state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              fire_prev_q;
    logic              fire_pulse_q;

    logic              fire_now;
    logic              press;
    logic              trigger;
    logic              any_free;
    logic              do_launch;
    logic [NUM_SHELLS-1:0] launch_sel;
    logic [NUM_SHELLS-1:0] launch_vec;
    logic [NUM_SHELLS-1:0] slot_active;
    coord_t            slot_x [NUM_SHELLS];
    coord_t            slot_y [NUM_SHELLS];
    coord_t            spawn_y;
    logic [NUM_SHELLS*10-1:0] shell_x_packed;
    logic [NUM_SHELLS*10-1:0] shell_y_packed;

    assign fire_now = is_fire_key(bus.keycode);
    assign press    = fire_now & ~fire_prev_q;

`ifdef SHELL_AUTOFIRE_EN
    // A held key re-arms as soon as the cooldown expires.
    assign trigger = fire_now | press;
`else
    assign trigger = press;
`endif

    // Lowest-index slot that was idle at the start of this frame; retiring slots still count as busy.
    always_comb begin
        launch_sel = '0;
        any_free   = 1'b0;
        for (int i = 0; i < NUM_SHELLS; i++) begin
            if (!slot_active[i] && !any_free) begin
                launch_sel[i] = 1'b1;
                any_free      = 1'b1;
            end
        end
    end

    // The height guard also keeps TankY - SPAWN_OFFSET from wrapping.
    assign do_launch  = (fire_state_q == tank_pkg::READY) && trigger && any_free &&
                        (bus.TankY >= SPAWN_MIN);
    assign launch_vec = launch_sel & {NUM_SHELLS{do_launch}};
    assign spawn_y    = bus.TankY - SPAWN_OFF;

    // Fire FSM: launch from READY, then ignore fire for the cooldown period.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            fire_state_q <= tank_pkg::READY;
            cnt_q        <= '0;
            fire_prev_q  <= 1'b0;
            fire_pulse_q <= 1'b0;
        end else begin
            fire_prev_q  <= fire_now;
            fire_pulse_q <= 1'b0;
            case (fire_state_q)
                tank_pkg::READY: begin
                    if (do_launch) begin
                        fire_state_q <= tank_pkg::COOLDOWN;
                        cnt_q        <= CNT_LOAD;
                        fire_pulse_q <= 1'b1;
                    end
                end
                tank_pkg::COOLDOWN: begin
                    if (cnt_q == '0) begin
                        fire_state_q <= tank_pkg::READY;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: fire_state_q <= tank_pkg::READY;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_SHELLS; g++) begin : g_slot
        shell_slot #(
            .SHELL_STEP (SHELL_STEP),
            .Y_MIN      (Y_MIN)
        ) u_slot (
            .frame_clk  (frame_clk),
            .Reset      (Reset),
            .launch_i   (launch_vec[g]),
            .spawn_x_i  (bus.TankX),
            .spawn_y_i  (spawn_y),
            .x_o        (slot_x[g]),
            .y_o        (slot_y[g]),
            .active_o   (slot_active[g])
        );
    end

    // Pack slot i into bits [10i+9:10i] of the flat coordinate buses.
    always_comb begin
        shell_x_packed = '0;
        shell_y_packed = '0;
        for (int i = 0; i < NUM_SHELLS; i++) begin
            shell_x_packed[10*i +: 10] = slot_x[i];
            shell_y_packed[10*i +: 10] = slot_y[i];
        end
    end

    assign bus.ShellX      = shell_x_packed;
    assign bus.ShellY      = shell_y_packed;
    assign bus.ShellActive = slot_active;
    assign bus.FirePulse   = fire_pulse_q;

endmodule

// File: tb/tb_shell_ctrl.sv
// tb/tb_shell_ctrl.sv - directed scoreboard bench for shell_ctrl
module tb_shell_ctrl;
    import tank_pkg::*;

    localparam int N = 4;

    typedef struct {
        int slot;
        int x;
        int y;
    } launch_t;

    logic frame_clk = 1'b0;
    logic Reset;

    shell_ctrl_if #(.NUM_SHELLS(N)) bus ();

    shell_ctrl #(
        .NUM_SHELLS   (N),
        .SHELL_STEP   (4),
        .SPAWN_OFFSET (8),
        .COOLDOWN     (15),
        .Y_MIN        (0)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    int      errs   = 0;
    int      checks = 0;
    launch_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int sx(input int s);
        return int'(bus.ShellX[s*10 +: 10]);
    endfunction

    function automatic int sy(input int s);
        return int'(bus.ShellY[s*10 +: 10]);
    endfunction

    task automatic frame();
        @(posedge frame_clk);
        #1;
        if (bus.FirePulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_fire", 1, 0);
            end else begin
                launch_t e;
                e = exp_q.pop_front();
                chk("launch_active", bus.ShellActive[e.slot], 1);
                chk("launch_x", sx(e.slot), e.x);
                chk("launch_y", sy(e.slot), e.y);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) frame();
    endtask

    task automatic press(input bit expect_launch, input int slot);
        launch_t e;
        bus.keycode = 8'h2C;
        if (expect_launch) begin
            e.slot = slot;
            e.x    = int'(bus.TankX);
            e.y    = int'(bus.TankY) - 8;
            exp_q.push_back(e);
        end
        frame();
        chk("fire_pulse", bus.FirePulse, expect_launch);
        bus.keycode = 8'h00;
    endtask

    task automatic do_reset();
        #2 Reset = 1'b1;
        @(posedge frame_clk);
        #2 Reset = 1'b0;
        exp_q.delete();
        bus.keycode = 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  launches;
        bit  exp_l;
        launch_t e;

        Reset       = 1'b1;
        bus.keycode = 8'h00;
        bus.TankX   = 10'd350;
        bus.TankY   = 10'd500;
        #12;
        chk("rst_active", bus.ShellActive, 0);
        chk("rst_x", bus.ShellX, 0);
        chk("rst_y", bus.ShellY, 0);
        chk("rst_pulse", bus.FirePulse, 0);
        Reset = 1'b0;

        // launch and move
        press(1, 0);
        frame();
        chk("move_pulse_low", bus.FirePulse, 0);
        chk("move_y", sy(0), 488);
        chk("move_active", bus.ShellActive, 4'b0001);

        // retire at the top boundary
        idle(122);
        chk("top_y", sy(0), 0);
        chk("top_active", bus.ShellActive[0], 1);
        frame();
        chk("retire_active", bus.ShellActive[0], 0);
        chk("retire_y_hold", sy(0), 0);
        chk("retire_x_hold", sx(0), 350);

        // cooldown: F+5 dropped, F+16 launches into slot1
        bus.TankX = 10'd100;
        bus.TankY = 10'd300;
        press(1, 0);
        idle(4);
        press(0, 0);
        idle(10);
        press(1, 1);
        chk("cool_active", bus.ShellActive, 4'b0011);

        // fill all slots, then a fifth press is dropped
        bus.TankX = 10'd200;
        idle(15);
        press(1, 2);
        bus.TankX = 10'd300;
        idle(15);
        press(1, 3);
        chk("full_active", bus.ShellActive, 4'b1111);
        idle(15);
        press(0, 0);
        chk("full_drop_active", bus.ShellActive, 4'b1111);

        n = 0;
        while (sy(0) != 0 && n < 100) begin
            frame();
            n++;
        end
        chk("slot0_top_reached", (sy(0) == 0), 1);

        // slot0 retires on this edge but is not reusable yet
        press(0, 0);
        chk("retire_frame_active", bus.ShellActive, 4'b1110);
        idle(1);
        bus.TankX = 10'd400;
        press(1, 0);
        chk("reuse_active", bus.ShellActive, 4'b1111);

        // asynchronous reset mid-flight and mid-cooldown
        idle(1);
        #2 Reset = 1'b1;
        #1;
        chk("async_active", bus.ShellActive, 0);
        chk("async_x", bus.ShellX, 0);
        chk("async_y", bus.ShellY, 0);
        chk("async_pulse", bus.FirePulse, 0);
        @(posedge frame_clk);
        #2 Reset = 1'b0;
        exp_q.delete();
        bus.TankX = 10'd123;
        bus.TankY = 10'd250;
        press(1, 0);
        chk("post_reset_active", bus.ShellActive, 4'b0001);

        // held fire key for 40 frames
        do_reset();
        bus.TankX   = 10'd50;
        bus.TankY   = 10'd400;
        bus.keycode = 8'h2C;
        launches    = 0;
        for (int i = 0; i < 40; i++) begin
`ifdef SHELL_AUTOFIRE_EN
            exp_l = (i % 16 == 0);
`else
            exp_l = (i == 0);
`endif
            if (exp_l) begin
                e.slot = launches;
                e.x    = 50;
                e.y    = 392;
                exp_q.push_back(e);
                launches++;
            end
            frame();
            chk("held_pulse", bus.FirePulse, exp_l);
        end
        bus.keycode = 8'h00;
        chk("held_active", bus.ShellActive, (1 << launches) - 1);

        // spawn height guard
        do_reset();
        bus.TankX = 10'd60;
        bus.TankY = 10'd5;
        press(0, 0);
        chk("guard_active", bus.ShellActive, 0);
        idle(1);
        bus.TankY = 10'd8;
        press(1, 0);
        frame();
        chk("edge_retire_active", bus.ShellActive[0], 0);
        chk("edge_retire_y", sy(0), 0);
        chk("edge_retire_x", sx(0), 60);

        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
